four_two_encoder_hs: RTL
========================

// Module: four_two_encoder_hs
// PURPOSE
//  Registered 4-to-2 encoder: the return path paired with the 2-4 decoder
//  (Cs/A1/A0 -> Y0..Y3). Samples four request lines Y0..Y3 under chip select
//  Cs and produces the 2-bit code {A1,A0} with a valid/ready handshake.
//  Sits between request sources and a consumer that re-drives the 2-4 decoder.
// PARAMETERS
//  CNT_W   8   width of the completed-handshake counter evt_cnt
// PORTS
//  clk         in   1      clock; all state updates on the rising edge
//  rst         in   1      reset, asynchronous, active-high
//  Cs          in   1      chip select; requests are sampled only when Cs=1
//  Y0..Y3      in   1 ea   request lines; Y3 is index 3
//  code_ready  in   1      consumer accepts the code when code_valid=1
//  A1,A0       out  1 ea   encoded index of the granted request, {A1,A0}
//  code_valid  out  1      {A1,A0,multi} hold a code
//  multi       out  1      more than one Y was high when the code was captured
//  evt_cnt     out  CNT_W  count of completed handshakes
// BEHAVIOUR
//  - Reset (async, while rst=1): A1=A0=0, code_valid=0, multi=0, evt_cnt=0,
//    state=IDLE, rr pointer=0. Asserting rst mid-handshake drops the held code.
//  - "req" = Cs & (Y0|Y1|Y2|Y3). Y lines are ignored when Cs=0.
//  - FSM states:
//    IDLE: on req, capture at this edge -> HOLD. code_valid=1 in the next
//          cycle (latency 1 clk from sample to valid). Otherwise stay in IDLE.
//    HOLD: A1,A0,multi are held stable until the handshake
//          (code_valid & code_ready) completes. At the handshake edge:
//          evt_cnt+1; if req on that same cycle -> capture the new code and
//          stay in HOLD (back-to-back, no bubble); else -> IDLE, code_valid=0.
//          Without a handshake, Y and Cs changes are ignored, and Cs=0 does
//          not abort the held code.
//  - multi = popcount({Y3,Y2,Y1,Y0}) >= 2 at the capture edge.
//  - evt_cnt wraps modulo 2^CNT_W (all-ones + 1 -> 0); it never saturates.
//  - code_ready while code_valid=0 has no effect.
// CONFIGURATION
//  ROUND_ROBIN_EN undefined: fixed priority Y3 > Y2 > Y1 > Y0; the highest
//    index set is granted.
//  ROUND_ROBIN_EN defined: 2-bit rotating pointer p (reset value 0). Search
//    order is p, p+1, p+2, p+3 (mod 4), and the first set line is granted.
//    At each capture granting index i, p <= (i+1) mod 4. p is unchanged
//    when no capture occurs.
// TESTING
//  1 rst=1 mid-run then release -> all outputs 0, evt_cnt=0, code_valid=0.
//  2 Cs=1, Y=0100 (Y2), code_ready=1 -> 1 clk later A1A0=10, valid=1,
//    multi=0; next edge -> evt_cnt=1, and valid=0 if Y=0000.
//  3 Cs=0, Y=1111 for 5 clks -> code_valid stays 0, evt_cnt unchanged.
//  4 Cs=1, Y=1011, code_ready=0 for 4 clks -> A1A0=11, multi=1 held stable;
//    Y changes ignored; raise ready -> one handshake, evt_cnt+1.
//  5 Y=0001, then 0010, ready=1 every clk -> codes 00 then 01 on consecutive
//    cycles with valid held high (back-to-back).
//  6 ROUND_ROBIN_EN, Y=1111 held, ready=1 -> grants 00,01,10,11,00...;
//    without the macro -> 11 every cycle, multi=1. CNT_W=2: 5 handshakes
//    -> evt_cnt=1.

Source files
------------

// File: rtl/four_two_encoder_hs.sv
// Registered 4-to-2 encoder with valid/ready output; code valid 1 clk after the sampling edge.
// Backpressure: the captured code is held until code_ready; back-to-back captures at the handshake edge.
// ROUND_ROBIN_EN selects rotating-pointer arbitration instead of fixed Y3>Y2>Y1>Y0 priority.
module four_two_encoder_hs #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Cs,
    input  logic             Y0,
    input  logic             Y1,
    input  logic             Y2,
    input  logic             Y3,
    input  logic             code_ready,
    output logic             A1,
    output logic             A0,
    output logic             code_valid,
    output logic             multi,
    output logic [CNT_W-1:0] evt_cnt
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] y_vec;
    logic       req;
    logic       hs;
    logic       capture;
    logic [1:0] grant_idx;
    logic [2:0] pop_cnt;
    logic       multi_nxt;
    logic [1:0] code_q;
    logic       multi_q;

    assign y_vec     = {Y3, Y2, Y1, Y0};
    assign req       = Cs & (|y_vec);
    assign hs        = (state == HOLD) & code_ready;
    assign pop_cnt   = {2'b00, y_vec[0]} + {2'b00, y_vec[1]} + {2'b00, y_vec[2]} + {2'b00, y_vec[3]};
    assign multi_nxt = (pop_cnt >= 3'd2);

`ifdef ROUND_ROBIN_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;

    // Scan offsets high to low so the nearest set line after rr_ptr wins.
    always_comb begin
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = rr_ptr + 2'(k);
            if (y_vec[cand]) begin
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 2'd0;
        end else if (capture) begin
            rr_ptr <= grant_idx + 2'd1;
        end
    end
`else
    always_comb begin
        grant_idx = 2'd0;
        casez (y_vec)
            4'b1???: grant_idx = 2'd3;
            4'b01??: grant_idx = 2'd2;
            4'b001?: grant_idx = 2'd1;
            default: grant_idx = 2'd0;
        endcase
    end
`endif

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hs) begin
                    if (req) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            code_q  <= 2'd0;
            multi_q <= 1'b0;
            evt_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                code_q  <= grant_idx;
                multi_q <= multi_nxt;
            end
            if (hs) begin
                evt_cnt <= evt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign code_valid = (state == HOLD);
    assign A1         = code_q[1];
    assign A0         = code_q[0];
    assign multi      = multi_q;

endmodule
